pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/hazard_pkg.sv | 35 +++
 rtl/hazard_load_use_detect.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and widths for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

  // Register-file address width (32 architectural registers, x0 hard-wired to zero).
  localparam int REG_ADDR_W = 5;

  // Width of the performance counters; they wrap modulo 2^PERF_CNT_W.
  localparam int PERF_CNT_W = 32;

  // Width of the memory-wait cycle counter; it saturates rather than wraps.
  localparam int WAIT_CNT_W = 16;

  // Controller states.
  //   RUN      : normal flow, hazards handled cycle by cycle.
  //   MEM_WAIT : data memory has been stalling the MEM stage.
  //   ERROR    : memory stall exceeded the timeout; only reset leaves it.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hazard_state_e;

  // Saturating increment for the wait counter.
  function automatic logic [WAIT_CNT_W-1:0] sat_inc(input logic [WAIT_CNT_W-1:0] val);
    logic [WAIT_CNT_W-1:0] res;
    res = val;
    if (val != {WAIT_CNT_W{1'b1}}) begin
      res = val + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/hazard_load_use_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a load in EX writes.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is consumed by the hazard FSM in the same cycle.
//
// Ports:
//   rs1_id, rs2_id   : source registers of the ID instruction
//   use_rs1, use_rs2 : ID instruction actually reads rs1 / rs2
//   rd_ex            : destination register of the EX instruction
//   mem_read_ex      : EX instruction is a load
//   load_use         : a one-bubble stall is needed
module hazard_load_use_detect
  import hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic                  use_rs1,
  input  logic                  use_rs2,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  mem_read_ex,
  output logic                  load_use
);

  logic rd_nonzero;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is never written, so a load targeting it cannot create a dependency.
  assign rd_nonzero = (rd_ex != '0);
  assign rs1_hit    = use_rs1 & (rs1_id == rd_ex);
  assign rs2_hit    = use_rs2 & (rs2_id == rd_ex);

  assign load_use   = mem_read_ex & rd_nonzero & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush generation for load-use, taken branches and slow data memory.
// Latency: stall/flush outputs are combinational from state and current inputs; memError_Out follows the state register.
// Backpressure: memory wait stalls IF..MEM and bubbles WB; a memory stall that outlives MEM_TIMEOUT freezes the pipe in ERROR until rst.
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the stall/flush performance counters;
// otherwise stallCount_Out / flushCount_Out are constant 0 and no counter flops exist.
//
// Ports:
//   clk, rst                  : clock (rising edge) and asynchronous active-high reset
//   rs1_Id_In, rs2_Id_In      : ID-stage source registers; useRs1_Id_In/useRs2_Id_In qualify them
//   rd_Ex_In, memRead_Ex_In   : EX-stage destination and "is a load" flag
//   branchTaken_Ex_In         : taken branch/jump resolved in EX
//   dMemReq_Mem_In            : MEM-stage data access active
//   dMemReady_Mem_In          : data memory completes the access this cycle
//   stall_*_Out               : hold PC, IF/ID, ID/EX, EX/MEM
//   flush_*_Out               : bubble into IF/ID, ID/EX, MEM/WB
//   memError_Out              : sticky memory-timeout flag
//   stallCount_Out            : cycles with stall_IF_Out high
//   flushCount_Out            : cycles with flush_ID_Out or flush_EX_Out high
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_Id_In,
  input  logic [REG_ADDR_W-1:0] rs2_Id_In,
  input  logic                  useRs1_Id_In,
  input  logic                  useRs2_Id_In,
  input  logic [REG_ADDR_W-1:0] rd_Ex_In,
  input  logic                  memRead_Ex_In,
  input  logic                  branchTaken_Ex_In,
  input  logic                  dMemReq_Mem_In,
  input  logic                  dMemReady_Mem_In,
  output logic                  stall_IF_Out,
  output logic                  stall_ID_Out,
  output logic                  stall_EX_Out,
  output logic                  stall_MEM_Out,
  output logic                  flush_ID_Out,
  output logic                  flush_EX_Out,
  output logic                  flush_WB_Out,
  output logic                  memError_Out,
  output logic [PERF_CNT_W-1:0] stallCount_Out,
  output logic [PERF_CNT_W-1:0] flushCount_Out
);

  // The cycle that takes the FSM from RUN into MEM_WAIT is itself a wait cycle,
  // and waitCnt is cleared on that entry. The MEM_WAIT cycle whose increment
  // brings waitCnt to MEM_TIMEOUT-1 is therefore the MEM_TIMEOUT-th consecutive
  // wait cycle; if memory is still not ready there, the next state is ERROR.
  localparam logic [31:0] LAST_WAIT = 32'(MEM_TIMEOUT - 1);

  hazard_state_e         state;
  hazard_state_e         state_nxt;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [WAIT_CNT_W-1:0] wait_cnt_nxt;
  logic [WAIT_CNT_W-1:0] wait_cnt_inc;
  logic                  timeout_hit;

  logic                  load_use;
  logic                  mem_wait;

  logic                  stall_if_c;
  logic                  stall_id_c;
  logic                  stall_ex_c;
  logic                  stall_mem_c;
  logic                  flush_id_c;
  logic                  flush_ex_c;
  logic                  flush_wb_c;

  // --------------------------------------------------------------------------
  // Hazard conditions
  // --------------------------------------------------------------------------
  hazard_load_use_detect u_load_use (
    .rs1_id      (rs1_Id_In),
    .rs2_id      (rs2_Id_In),
    .use_rs1     (useRs1_Id_In),
    .use_rs2     (useRs2_Id_In),
    .rd_ex       (rd_Ex_In),
    .mem_read_ex (memRead_Ex_In),
    .load_use    (load_use)
  );

  assign mem_wait     = dMemReq_Mem_In & ~dMemReady_Mem_In;
  assign wait_cnt_inc = sat_inc(wait_cnt);
  assign timeout_hit  = ({{(32-WAIT_CNT_W){1'b0}}, wait_cnt_inc} >= LAST_WAIT);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and stall/flush decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    stall_if_c   = 1'b0;
    stall_id_c   = 1'b0;
    stall_ex_c   = 1'b0;
    stall_mem_c  = 1'b0;
    flush_id_c   = 1'b0;
    flush_ex_c   = 1'b0;
    flush_wb_c   = 1'b0;

    unique case (state)
      RUN: begin
        if (mem_wait) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = '0;
        end
      end
      MEM_WAIT: begin
        if (!mem_wait) begin
          // Ready (or request dropped) wins even in the last allowed cycle.
          state_nxt = RUN;
        end else begin
          wait_cnt_nxt = wait_cnt_inc;
          if (timeout_hit) begin
            state_nxt = ERROR;
          end
        end
      end
      ERROR: begin
        state_nxt = ERROR;
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase

    // Output priority: ERROR freeze, then memory wait, then taken branch
    // (which squashes the dependent instruction, so no load-use bubble is
    // needed), then load-use. RUN and MEM_WAIT decode identically, so the
    // ready cycle of a memory wait services a pending branch/load-use.
    if (state == ERROR || mem_wait) begin
      stall_if_c  = 1'b1;
      stall_id_c  = 1'b1;
      stall_ex_c  = 1'b1;
      stall_mem_c = 1'b1;
      flush_wb_c  = 1'b1;
    end else if (branchTaken_Ex_In) begin
      flush_id_c  = 1'b1;
      flush_ex_c  = 1'b1;
    end else if (load_use) begin
      stall_if_c  = 1'b1;
      stall_id_c  = 1'b1;
      flush_ex_c  = 1'b1;
    end
  end

  // Outputs are forced low for as long as rst is held, independent of inputs.
  assign stall_IF_Out  = stall_if_c  & ~rst;
  assign stall_ID_Out  = stall_id_c  & ~rst;
  assign stall_EX_Out  = stall_ex_c  & ~rst;
  assign stall_MEM_Out = stall_mem_c & ~rst;
  assign flush_ID_Out  = flush_id_c  & ~rst;
  assign flush_EX_Out  = flush_ex_c  & ~rst;
  assign flush_WB_Out  = flush_wb_c  & ~rst;
  assign memError_Out  = (state == ERROR) & ~rst;

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  localparam logic [PERF_CNT_W-1:0] CNT_ONE = {{(PERF_CNT_W-1){1'b0}}, 1'b1};

  logic [PERF_CNT_W-1:0] stall_cnt;
  logic [PERF_CNT_W-1:0] flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_IF_Out) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (flush_ID_Out || flush_EX_Out) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

  assign stallCount_Out = stall_cnt;
  assign flushCount_Out = flush_cnt;
`else
  assign stallCount_Out = '0;
  assign flushCount_Out = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model (consecutive-wait counting, priority rules).
module tb_pipeline_hazard_ctrl;

  localparam int TO = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [4:0]  rs1, rs2, rd;
  logic        use1, use2, mrd, br, req, rdy;
  logic        s_if, s_id, s_ex, s_mem, f_id, f_ex, f_wb, merr;
  logic [31:0] scnt, fcnt;

  int total;
  int bad;

  // Model state: error flag, run length of consecutive wait cycles, counters.
  bit          m_err;
  int          m_consec;
  logic [31:0] m_scnt;
  logic [31:0] m_fcnt;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk               (clk),
    .rst               (rst),
    .rs1_Id_In         (rs1),
    .rs2_Id_In         (rs2),
    .useRs1_Id_In      (use1),
    .useRs2_Id_In      (use2),
    .rd_Ex_In          (rd),
    .memRead_Ex_In     (mrd),
    .branchTaken_Ex_In (br),
    .dMemReq_Mem_In    (req),
    .dMemReady_Mem_In  (rdy),
    .stall_IF_Out      (s_if),
    .stall_ID_Out      (s_id),
    .stall_EX_Out      (s_ex),
    .stall_MEM_Out     (s_mem),
    .flush_ID_Out      (f_id),
    .flush_EX_Out      (f_ex),
    .flush_WB_Out      (f_wb),
    .memError_Out      (merr),
    .stallCount_Out    (scnt),
    .flushCount_Out    (fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Expected {stall IF,ID,EX,MEM, flush ID,EX,WB} from the priority rules.
  function automatic logic [6:0] model_out(input bit r, input bit err);
    bit lu;
    bit mw;
    if (r) return 7'b0;
    lu = mrd && (rd != 5'd0) && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
    mw = req && !rdy;
    if (err || mw) return 7'b1111_001;
    if (br)        return 7'b0000_110;
    if (lu)        return 7'b1100_010;
    return 7'b0;
  endfunction

  function automatic logic [6:0] dut_out();
    return {s_if, s_id, s_ex, s_mem, f_id, f_ex, f_wb};
  endfunction

  task automatic model_clear();
    m_err    = 1'b0;
    m_consec = 0;
    m_scnt   = '0;
    m_fcnt   = '0;
  endtask

  // One clock cycle: inputs already applied; check at negedge, advance model at posedge.
  task automatic step(input string tag);
    logic [6:0] exp;
    @(negedge clk);
    if (rst) model_clear();
    exp = model_out(rst, m_err);
    chk({tag, ".ctl"},  32'(dut_out()), 32'(exp));
    chk({tag, ".err"},  32'(merr), 32'(m_err && !rst));
    chk({tag, ".scnt"}, scnt, m_scnt);
    chk({tag, ".fcnt"}, fcnt, m_fcnt);
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (PERF) begin
        if (exp[6])          m_scnt = m_scnt + 32'd1;
        if (exp[2] | exp[1]) m_fcnt = m_fcnt + 32'd1;
      end
      if (!m_err) begin
        if (req && !rdy) begin
          m_consec++;
          if (m_consec >= TO) m_err = 1'b1;
        end else begin
          m_consec = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    use1 = 1'b0; use2 = 1'b0; mrd = 1'b0; br = 1'b0;
    req = 1'b0; rdy = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step("rst");
    rst = 1'b0;
  endtask

  task automatic set_lu();
    rd = 5'd5; mrd = 1'b1; rs1 = 5'd5; use1 = 1'b1;
  endtask

  int n;

  initial begin
    total = 0;
    bad   = 0;
    model_clear();
    rst = 1'b1;
    idle();
    #1;
    chk("reset.ctl",  32'(dut_out()), 32'd0);
    chk("reset.err",  32'(merr), 32'd0);
    chk("reset.scnt", scnt, 32'd0);
    step("reset");
    rst = 1'b0;

    // Load-use: one bubble, then the dependency is gone.
    set_lu();
    #1;
    chk("lu.stall_if", 32'(s_if), 32'd1);
    chk("lu.stall_id", 32'(s_id), 32'd1);
    chk("lu.flush_ex", 32'(f_ex), 32'd1);
    chk("lu.stall_ex", 32'(s_ex), 32'd0);
    step("lu");
    idle();
    step("lu_after");
    set_lu(); rd = 5'd0; rs1 = 5'd0;
    #1;
    chk("lu_x0.stall_if", 32'(s_if), 32'd0);
    step("lu_x0");

    // Branch beats load-use.
    set_lu(); br = 1'b1;
    #1;
    chk("br.flush_id", 32'(f_id), 32'd1);
    chk("br.flush_ex", 32'(f_ex), 32'd1);
    chk("br.stall_if", 32'(s_if), 32'd0);
    step("br");
    idle();

    // Memory wait of 3 cycles, then ready with a pending branch.
    n = 0;
    req = 1'b1; rdy = 1'b0;
    set_lu(); br = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (s_if && s_id && s_ex && s_mem && f_wb && !f_id && !f_ex) n++;
      step("mw");
    end
    rdy = 1'b1;
    #1;
    chk("mw.cycles", 32'(n), 32'd3);
    chk("mw.ready_stall", 32'(s_if | s_mem | f_wb), 32'd0);
    chk("mw.ready_branch", 32'(f_id), 32'd1);
    step("mw_rdy");
    idle();
    step("mw_post");

    // Timeout: never ready -> error from the 5th cycle, held until reset.
    req = 1'b1; rdy = 1'b0;
    for (int i = 0; i < TO; i++) begin
      #1;
      chk("to.early_err", 32'(merr), 32'd0);
      step("to");
    end
    #1;
    chk("to.err", 32'(merr), 32'd1);
    step("to_err");
    idle();
    step("to_hold");
    #1;
    chk("to.hold_err", 32'(merr), 32'd1);
    chk("to.hold_ctl", 32'(dut_out()), 32'(7'b1111_001));
    // Asynchronous reset out of ERROR.
    #1;
    rst = 1'b1;
    #1;
    chk("to.async_rst", 32'(merr), 32'd0);
    chk("to.async_ctl", 32'(dut_out()), 32'd0);
    rst = 1'b0;
    model_clear();
    step("to_post_rst");

    // Ready in cycle TO: no error.
    req = 1'b1; rdy = 1'b0;
    for (int i = 0; i < TO - 1; i++) step("late");
    rdy = 1'b1;
    step("late_rdy");
    idle();
    #1;
    chk("late.no_err", 32'(merr), 32'd0);
    step("late_post");

    // Reset pulse in the middle of a memory wait.
    req = 1'b1; rdy = 1'b0;
    step("mid");
    step("mid");
    #1;
    rst = 1'b1;
    #1;
    chk("mid.rst_ctl", 32'(dut_out()), 32'd0);
    chk("mid.rst_scnt", scnt, 32'd0);
    rst = 1'b0;
    req = 1'b0;
    model_clear();
    step("mid_post");
    #1;
    chk("mid.run", 32'(dut_out() | 7'(merr)), 32'd0);

    // Performance counters: 2 load-use stalls + 1 branch flush.
    do_reset();
    set_lu();  step("pc_lu1");
    idle();    step("pc_gap");
    set_lu();  step("pc_lu2");
    idle(); br = 1'b1; step("pc_br");
    idle();
    #1;
    chk("pc.stall", scnt, PERF ? 32'd2 : 32'd0);
    chk("pc.flush", fcnt, PERF ? 32'd3 : 32'd0);
    step("pc_post");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 49) == 0);
      rs1  = 5'($urandom_range(0, 3));
      rs2  = 5'($urandom_range(0, 3));
      rd   = 5'($urandom_range(0, 3));
      use1 = 1'($urandom_range(0, 1));
      use2 = 1'($urandom_range(0, 1));
      mrd  = 1'($urandom_range(0, 1));
      br   = ($urandom_range(0, 4) == 0);
      req  = ($urandom_range(0, 9) < 6);
      rdy  = ($urandom_range(0, 9) < 4);
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
